button_bit_conditioner: RTL
===========================

# button_bit_conditioner

Front-end stage that turns the raw active-low serial-input push-button into a clean, one-bit-per-step input for the sequence-detector FSM. It synchronises and debounces the button and generates a periodic step strobe (`tick`) that replaces the divided slow clock. It also latches any press seen during a step window, so the FSM consumes exactly one bit per step. It sits between the board pin and the FSM, and the FSM's `x` and clock enable are fed from `x_out` and `tick`.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable clk cycles (20 ms at 50 MHz) required to accept a button level change; legal range ≥ 1.
- `TICK_DIV`, default 25000000: clk cycles per step (2 Hz at 50 MHz); legal range ≥ 2.
- `clk`  in  1  50 MHz system clock; only clock in the block.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw button pin, asynchronous, active low (0 = pressed).
- `tick`  out  1  one-cycle step strobe, high once every `TICK_DIV` cycles.
- `x_out`  out  1  bit presented to the FSM for the current step window; held between ticks.
- `press`  out  1  one-cycle pulse on each accepted (debounced) press.
- `level`  out  1  debounced button state, 1 = pressed.

## Operation
- Synchroniser: two flops on `btn_n`, both reset to 1 (released). The inverted second-stage output `s` (1 = pressed) is the only signal the debouncer sees.
- Debouncer: counter `dcnt`, width ceil(log2(`DEBOUNCE_CYCLES`+1)).
  - When `s == level`, `dcnt` clears to 0.
  - When `s != level` and `dcnt == DEBOUNCE_CYCLES-1`, `level` toggles and `dcnt` clears.
  - Otherwise, `dcnt` increments.
  - Any glitch back to `s == level` restarts the count from 0.
- Press detect: `press` is registered and asserts on the same edge where `level` goes 0→1. There is no pulse on release.
- Step timer: counter `tcnt`, counts 0..`TICK_DIV`-1 and wraps. `tick` is registered and asserts during the cycle after `tcnt` reaches `TICK_DIV`-1, so it is high exactly one cycle per `TICK_DIV` cycles. The first `tick` occurs `TICK_DIV` cycles after reset release.
- Press latch `pending`:
  - Set by `press`.
  - On a cycle with `tick` high: `x_out <= pending | press`, and `pending <= 0`.
  - A press coinciding with `tick` goes into this step, not the next one.
  - Multiple presses in one window collapse to a single 1.
  - A window with no press yields `x_out = 0`.
- `x_out` changes only on tick cycles. The FSM samples `x_out` on its next enabled edge, so it always sees a stable bit for the whole step.
- Holding the button across several windows produces only one 1, because a single press gives a single bit.

## Timing
- Reset values (asynchronous, immediate): `tick = 0`, `x_out = 0`, `press = 0`, `level = 0`, `pending = 0`, `dcnt = 0`, `tcnt = 0`, sync flops = 1.
- Latency from a `btn_n` falling edge to `press`/`level` high:
  - 2 cycles through the synchroniser, plus `DEBOUNCE_CYCLES` cycles of stable `s`.
  - `level` and `press` register on the edge ending the `DEBOUNCE_CYCLES`-th cycle in which `s != level`.
- Release latency is identical and produces no pulse.
- Latency from `press` to `x_out`: up to `TICK_DIV` cycles (next tick).
- Reset asserted mid-debounce or mid-window: all state clears. A button held through reset release must be re-accepted via a full debounce and then gives a press. A pending bit is lost.
- `DEBOUNCE_CYCLES = 1`: a level change is accepted after one cycle of difference.
- No combinational path from any input to any output.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES = 4`, `TICK_DIV = 16`.
- Reset then idle (`btn_n = 1`) for 100 cycles -> all outputs 0 at reset. `tick` pulses at cycles 16, 32, 48, … after release, each exactly one cycle wide. `x_out` stays 0.
- Clean press: drive `btn_n` low at cycle 3 and hold -> `level` and `press` go high 6 cycles later. `press` is one cycle wide. At the next tick `x_out = 1`, and at the following tick `x_out = 0` while `level` is still 1.
- Bounce: `btn_n` toggles every 2 cycles for 20 cycles, then stays high -> `level`, `press` and `x_out` remain 0 throughout.
- Two clean presses (with release) inside one window -> two `press` pulses, a single `x_out = 1` window, and `x_out = 0` on the next tick.
- Press aligned so `press` coincides with `tick` -> `x_out = 1` from that tick, and the next tick gives `x_out = 0` (the press is not double-counted).
- Reset asserted 2 cycles before `level` would flip, button still held -> outputs clear immediately. After release, `press` fires 6 cycles later (fresh synchroniser plus full debounce).

Source files
------------

// File: rtl/button_bit_conditioner.sv
// Button front end for the sequence detector: it synchronises and debounces the
// active-low button, generates the step strobe and latches one bit per step window.
module button_bit_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic tick,
  output logic x_out,
  output logic press,
  output logic level
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

  logic          sync0;
  logic          sync1;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          accept;
  logic [TW-1:0] tcnt;
  logic          pending;

  // Both stages reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= btn_n;
      sync1 <= sync0;
    end
  end

  always_comb begin
    s      = ~sync1;
    accept = (s != level) && (dcnt == DCNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt  <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= accept & ~level;
      if (accept) begin
        level <= ~level;
        dcnt  <= '0;
      end else if (s == level) begin
        dcnt  <= '0;
      end else begin
        dcnt  <= dcnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (tcnt == TCNT_LAST);
      if (tcnt == TCNT_LAST) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  // A press arriving in the tick cycle itself is folded into the closing window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      x_out   <= 1'b0;
    end else if (tick) begin
      x_out   <= pending | press;
      pending <= 1'b0;
    end else if (press) begin
      pending <= 1'b1;
    end
  end

endmodule
